alu_op_sequencer: RTL and testbench

Time-shares one 4-bit ALU datapath (an 8-to-1 function-select result mux driven by a 3-bit select) between up to four requesters. Each requester posts an opcode and two operands. The block picks one requester round-robin, drives the ALU select and operand lines, waits a fixed settle time, captures the ALU result and returns it with a one-cycle done pulse. It sits between the requesting units and the ALU, and is the only driver of the ALU select lines.

---
 rtl/alu_op_sequencer.sv | 105 ++++++++++
 tb/tb_alu_op_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: round-robin time-sharing of one ALU between NREQ requesters
module alu_op_sequencer #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     op_bus,
    input  logic [WIDTH*NREQ-1:0] a_bus,
    input  logic [WIDTH*NREQ-1:0] b_bus,
    input  logic [WIDTH-1:0]      alu_result,
    output logic [2:0]            f_sel,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state, state_nx;
    logic [2:0] cnt;
    logic [1:0] ptr, win, pick;
    logic       found;

    // round-robin search starting at ptr; 2-bit index arithmetic wraps mod 4
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                pick  = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? ISSUE : IDLE;
            ISSUE:   state_nx = (cnt == 3'd0) ? RESP : ISSUE;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy derives from the state register only
    always_comb begin
        busy = (state != IDLE);
    end

    // grant snapshot, latency count, result capture and release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ptr    <= '0;
            win    <= '0;
            gnt    <= '0;
            done   <= '0;
            f_sel  <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    gnt   <= NREQ'(1) << pick;
                    win   <= pick;
                    f_sel <= op_bus[3*pick +: 3];
                    alu_a <= a_bus[WIDTH*pick +: WIDTH];
                    alu_b <= b_bus[WIDTH*pick +: WIDTH];
                    cnt   <= 3'(ALU_LAT - 1);
                end
                ISSUE: if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                end else begin
                    result <= alu_result;
                    done   <= gnt;
                end
                RESP: begin
                    ptr   <= win + 2'd1;
                    gnt   <= '0;
                    done  <= '0;
                    f_sel <= '0;
                    alu_a <= '0;
                    alu_b <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks on a mux-model ALU (LAT=1) and an adder-model ALU (LAT=4)
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req1 = '0, req4 = '0;
    logic [11:0] op_bus = '0;
    logic [15:0] a_bus = '0, b_bus = '0;
    logic [3:0]  ar1, ar4;
    logic [2:0]  f_sel1, f_sel4;
    logic [3:0]  alu_a1, alu_b1, alu_a4, alu_b4;
    logic [3:0]  gnt1, gnt4, done1, done4, res1, res4;
    logic        busy1, busy4;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    // mux ALU with constant inputs 0..7, and an adder ALU
    assign ar1 = {1'b0, f_sel1};
    assign ar4 = alu_a4 + alu_b4;

    alu_op_sequencer #(.NREQ(4), .WIDTH(4), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op_bus(op_bus), .a_bus(a_bus), .b_bus(b_bus),
        .alu_result(ar1), .f_sel(f_sel1), .alu_a(alu_a1), .alu_b(alu_b1), .gnt(gnt1),
        .busy(busy1), .done(done1), .result(res1)
    );

    alu_op_sequencer #(.NREQ(4), .WIDTH(4), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .op_bus(op_bus), .a_bus(a_bus), .b_bus(b_bus),
        .alu_result(ar4), .f_sel(f_sel4), .alu_a(alu_a4), .alu_b(alu_b4), .gnt(gnt4),
        .busy(busy4), .done(done4), .result(res4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req1 = 4'b1111; req4 = 4'b1111;
        tick(); tick();
        n_checks++; if ({gnt1, done1, busy1} !== 9'd0) begin n_fail++; $display("FAIL reset_ctl1 got %b want 0", {gnt1, done1, busy1}); end
        n_checks++; if ({f_sel1, alu_a1, alu_b1, res1} !== 15'd0) begin n_fail++; $display("FAIL reset_dp1 got %h want 0", {f_sel1, alu_a1, alu_b1, res1}); end
        n_checks++; if ({gnt4, done4, busy4, f_sel4, alu_a4, alu_b4, res4} !== 24'd0) begin n_fail++; $display("FAIL reset_all4 got %h want 0", {gnt4, done4, busy4, f_sel4, alu_a4, alu_b4, res4}); end
        req1 = '0; req4 = '0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        op_bus[2:0] = 3'd3; a_bus[3:0] = 4'd5; b_bus[3:0] = 4'd9; req1 = 4'b0001;
        tick();
        n_checks++; if ({f_sel1, alu_a1, alu_b1} !== {3'd3, 4'd5, 4'd9}) begin n_fail++; $display("FAIL single_operands got %h/%h/%h want 3/5/9", f_sel1, alu_a1, alu_b1); end
        n_checks++; if ({gnt1, busy1, done1} !== {4'b0001, 1'b1, 4'b0000}) begin n_fail++; $display("FAIL single_grant got gnt=%b busy=%b done=%b", gnt1, busy1, done1); end
        tick();
        n_checks++; if (done1 !== 4'b0001 || res1 !== 4'd3) begin n_fail++; $display("FAIL single_done got done=%b res=%h want 0001/3", done1, res1); end
        req1 = '0;
        tick();
        n_checks++; if ({gnt1, done1, busy1, f_sel1} !== 12'd0 || res1 !== 4'd3) begin n_fail++; $display("FAIL single_release got gnt=%b done=%b busy=%b f=%h res=%h", gnt1, done1, busy1, f_sel1, res1); end
    endtask

    task automatic test_back_to_back;
        int np, t_last;
        logic [3:0] exp;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        op_bus = {3'd7, 3'd6, 3'd5, 3'd4};
        req1 = 4'b1111; np = 0; t_last = 0;
        for (int c = 0; c < 40 && np < 5; c++) begin
            tick();
            if (done1 != 4'b0000) begin
                exp = 4'b0001 << (np % 4);
                n_checks++; if (done1 !== exp) begin n_fail++; $display("FAIL rr_order[%0d] got %b want %b", np, done1, exp); end
                n_checks++; if (res1 !== 4'(4 + np % 4)) begin n_fail++; $display("FAIL rr_result[%0d] got %h want %h", np, res1, 4'(4 + np % 4)); end
                if (np > 0) begin
                    n_checks++; if (c - t_last != 3) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want 3", np, c - t_last); end
                end
                t_last = c; np++;
                if (np == 5) req1 = '0;
            end
        end
        n_checks++; if (np != 5) begin n_fail++; $display("FAIL rr_count got %0d want 5", np); end
        tick();
    endtask

    task automatic test_wrap;
        req1 = 4'b0100;
        tick();
        n_checks++; if (gnt1 !== 4'b0100) begin n_fail++; $display("FAIL wrap_first got %b want 0100", gnt1); end
        tick(); req1 = '0; tick();
        req1 = 4'b0101;
        tick();
        n_checks++; if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant got %b want 0001", gnt1); end
        tick();
        n_checks++; if (done1 !== 4'b0001 || res1 !== 4'd4) begin n_fail++; $display("FAIL wrap_done got done=%b res=%h want 0001/4", done1, res1); end
        req1 = '0; tick();
    endtask

    task automatic test_latency;
        a_bus[3:0] = 4'hF; b_bus[3:0] = 4'h2; req4 = 4'b0001;
        tick();
        n_checks++; if ({gnt4, alu_a4, alu_b4, busy4} !== {4'b0001, 4'hF, 4'h2, 1'b1}) begin n_fail++; $display("FAIL lat_grant got gnt=%b a=%h b=%h busy=%b", gnt4, alu_a4, alu_b4, busy4); end
        a_bus[3:0] = 4'h0;
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++; if (done4 !== 4'b0000) begin n_fail++; $display("FAIL lat_early[%0d] got %b want 0000", i, done4); end
        end
        tick();
        n_checks++; if (done4 !== 4'b0001 || res4 !== 4'h1 || alu_a4 !== 4'hF) begin n_fail++; $display("FAIL lat_done got done=%b res=%h a=%h want 0001/1/F", done4, res4, alu_a4); end
        req4 = '0;
        tick();
        n_checks++; if ({gnt4, done4, busy4} !== 9'd0) begin n_fail++; $display("FAIL lat_release got %b want 0", {gnt4, done4, busy4}); end
    endtask

    task automatic test_reset_abort;
        req4 = 4'b0010;
        tick();
        n_checks++; if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL abort_grant got %b want 0010", gnt4); end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if ({gnt4, busy4, done4, f_sel4} !== 12'd0) begin n_fail++; $display("FAIL abort_async got gnt=%b busy=%b done=%b f=%h", gnt4, busy4, done4, f_sel4); end
        req4 = 4'b1111;
        tick();
        n_checks++; if (done4 !== 4'b0000) begin n_fail++; $display("FAIL abort_nodone got %b want 0000", done4); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL abort_regrant got %b want 0001", gnt4); end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++; if (done4 !== 4'b0000) begin n_fail++; $display("FAIL abort_early[%0d] got %b want 0000", i, done4); end
        end
        tick();
        n_checks++; if (done4 !== 4'b0001 || res4 !== 4'h2) begin n_fail++; $display("FAIL abort_done got done=%b res=%h want 0001/2", done4, res4); end
        req4 = '0; tick();
    endtask

    task automatic test_withdraw;
        req1 = 4'b0010;
        tick();
        n_checks++; if (gnt1 !== 4'b0010) begin n_fail++; $display("FAIL wd_grant got %b want 0010", gnt1); end
        req1 = '0;
        tick();
        n_checks++; if (done1 !== 4'b0010 || res1 !== 4'd5) begin n_fail++; $display("FAIL wd_done got done=%b res=%h want 0010/5", done1, res1); end
        tick();
        n_checks++; if ({gnt1, done1, busy1} !== 9'd0) begin n_fail++; $display("FAIL wd_release got %b want 0", {gnt1, done1, busy1}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_latency();
        test_reset_abort();
        test_withdraw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
